exp_pipe: RTL and testbench

EXP_PIPE -- requirements
Module: exp

---
 rtl/exp_pkg.sv | 55 +++++
 rtl/exp_taylor_stage.sv | 40 ++++
 rtl/exp_pipe.sv | 96 +++++++++
 tb/tb_exp_pipe.sv | 119 +++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared fixed-point formats, constants and stage bundle for the exp() pipeline.
package exp_pkg;

  // Operand and result format: Q6.10
  localparam int IN_W    = 16;
  localparam int IN_FRAC = 10;

  // Working format inside the pipeline: 32-bit signed with 20 fraction bits
  localparam int FB = 20;
  localparam int WW = 32;
  localparam int PW = 64;
  localparam int K_W = 8;
  localparam int SH_W = 10;

  // 1/ln2 in Q1.16 and ln2 in Q.20
  localparam int INV_LN2_FRAC = 16;
  localparam logic signed [PW-1:0] INV_LN2 = 64'sd94548;
  localparam logic signed [PW-1:0] LN2     = 64'sd726817;

  // k = round(x/ln2): product is Q.26, add half before the floor shift
  localparam int K_SHIFT = INV_LN2_FRAC + IN_FRAC;
  localparam logic signed [PW-1:0] K_HALF = 64'sd1 <<< (K_SHIFT - 1);

  localparam logic signed [PW-1:0] ONE_W = 64'sd1 <<< FB;

  // ln(64) in Q6.10; anything above saturates
  localparam logic signed [IN_W-1:0] SAT_THRESH = 16'sh10A2;
  localparam logic [IN_W-1:0]        OUT_MAX    = 16'hFFFF;

  // Running power, running sum, residual and scale exponent carried per stage
  typedef struct packed {
    logic signed [WW-1:0]  r;
    logic signed [WW-1:0]  p;
    logic signed [WW-1:0]  sum;
    logic signed [K_W-1:0] k;
    logic                  sat;
  } stage_t;

  // 1/i! in Q.20
  function automatic logic signed [WW-1:0] inv_fact(input int i);
    case (i)
      0:       inv_fact = 32'sd1048576;
      1:       inv_fact = 32'sd1048576;
      2:       inv_fact = 32'sd524288;
      3:       inv_fact = 32'sd174763;
      4:       inv_fact = 32'sd43691;
      5:       inv_fact = 32'sd8738;
      6:       inv_fact = 32'sd1456;
      7:       inv_fact = 32'sd208;
      8:       inv_fact = 32'sd26;
      default: inv_fact = 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/exp_taylor_stage.sv
// One Taylor term: p <- p*r, sum <- sum + p/IDX!, everything else passed through.
module exp_taylor_stage
  import exp_pkg::*;
#(
  parameter int IDX = 1
) (
  input  logic   CLK,
  input  logic   RST,
  input  stage_t d_stage,
  output stage_t q_stage
);

  localparam logic signed [PW-1:0] COEF = PW'(inv_fact(IDX));

  logic signed [PW-1:0] p_ext;
  logic signed [PW-1:0] r_ext;
  logic signed [PW-1:0] p_prod;
  logic signed [PW-1:0] p_next;
  logic signed [PW-1:0] t_prod;
  stage_t               nxt;

  // Full-width products, truncated back to the working format afterwards
  always_comb begin
    nxt     = d_stage;
    p_ext   = {{(PW-WW){d_stage.p[WW-1]}}, d_stage.p};
    r_ext   = {{(PW-WW){d_stage.r[WW-1]}}, d_stage.r};
    p_prod  = p_ext * r_ext;
    p_next  = p_prod >>> FB;
    t_prod  = p_next * COEF;
    nxt.p   = WW'(p_next);
    nxt.sum = d_stage.sum + WW'(t_prod >>> FB);
  end

  // Stage register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q_stage <= '0;
    else     q_stage <= nxt;
  end

endmodule

// File: rtl/exp_pipe.sv
// Fully pipelined exp(x): range reduction, N_STAGE Taylor terms, 2^k scaling.
module exp_pipe
  import exp_pkg::*;
#(
  parameter int N_STAGE = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [IN_W-1:0] data,
  output logic [IN_W-1:0] output_data,
  output logic            write_enable
);

  localparam int L = N_STAGE + 2;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] k_prod;
  logic signed [PW-1:0] k_full;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] r_full;
  stage_t               s0_d;
  stage_t               s0_q;
  stage_t               pipe [0:N_STAGE];

  logic signed [SH_W-1:0] sh;
  logic [5:0]             sh_c;
  logic [PW-1:0]          sum_u;
  logic [PW-1:0]          rnd;
  logic [IN_W-1:0]        res;
  logic [L-1:0]           vld;

  // Range reduction: k = round(x/ln2), r = x - k*ln2 in Q.20
  always_comb begin
    s0_d     = '0;
    x_ext    = {{(PW-IN_W){data[IN_W-1]}}, data};
    k_prod   = x_ext * INV_LN2 + K_HALF;
    k_full   = k_prod >>> K_SHIFT;
    s0_d.k   = K_W'(k_full);
    k_ext    = {{(PW-K_W){s0_d.k[K_W-1]}}, s0_d.k};
    r_full   = (x_ext <<< (FB - IN_FRAC)) - k_ext * LN2;
    s0_d.r   = WW'(r_full);
    s0_d.p   = WW'(ONE_W);
    s0_d.sum = WW'(ONE_W);
    s0_d.sat = $signed(data) > SAT_THRESH;
  end

  // Stage 0 register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) s0_q <= '0;
    else     s0_q <= s0_d;
  end

  assign pipe[0] = s0_q;

  for (genvar i = 1; i <= N_STAGE; i++) begin : g_stage
    exp_taylor_stage #(.IDX(i)) u_stage (
      .CLK     (CLK),
      .RST     (RST),
      .d_stage (pipe[i-1]),
      .q_stage (pipe[i])
    );
  end

  // Scale by 2^k and round into Q6.10; sh = 10 - k is the right-shift from Q.20
  always_comb begin
    sh    = SH_W'(FB - IN_FRAC) - {{(SH_W-K_W){pipe[N_STAGE].k[K_W-1]}}, pipe[N_STAGE].k};
    sh_c  = 6'd40;
    sum_u = {{(PW-WW){1'b0}}, pipe[N_STAGE].sum};
    rnd   = '0;
    res   = '0;
    if (pipe[N_STAGE].sat || sh < 10'sd1) begin
      res = OUT_MAX;
    end else if (pipe[N_STAGE].sum <= 0) begin
      res = '0;
    end else begin
      sh_c = (sh > 10'sd40) ? 6'd40 : sh[5:0];
      rnd  = (sum_u + (64'd1 << (sh_c - 6'd1))) >> sh_c;
      res  = (rnd > 64'h0000_0000_0000_FFFF) ? OUT_MAX : rnd[IN_W-1:0];
    end
  end

  // Output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) output_data <= '0;
    else     output_data <= res;
  end

  // Valid shift register tracking samples taken since reset release
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld <= '0;
    else     vld <= {vld[L-2:0], 1'b1};
  end

  assign write_enable = vld[L-1];

endmodule

// File: tb/tb_exp_pipe.sv
// Directed bench for exp_pipe at N_STAGE = 4, 3 and 6 sharing one stimulus stream.
module tb_exp_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] data;
  logic [15:0] od4, od3, od6;
  logic        we4, we3, we6;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  logic [15:0] cap_exp [0:63];
  int          cap_tol [0:63];
  bit          cap_on  [0:63];

  always #5 CLK = ~CLK;

  exp_pipe #(.N_STAGE(4)) dut4 (.CLK(CLK), .RST(RST), .data(data), .output_data(od4), .write_enable(we4));
  exp_pipe #(.N_STAGE(3)) dut3 (.CLK(CLK), .RST(RST), .data(data), .output_data(od3), .write_enable(we3));
  exp_pipe #(.N_STAGE(6)) dut6 (.CLK(CLK), .RST(RST), .data(data), .output_data(od6), .write_enable(we6));

  task automatic chk(input string tag, input int obs, input int exp_v, input int tol);
    int diff;
    n_chk++;
    diff = obs - exp_v;
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0h, need %0h (+/- %0d)", tag, obs, exp_v, tol);
  endtask

  // Result of the sample captured at edge (edge_n - L + 1) is due now
  task automatic chk_dut(input int n, input logic [15:0] od, input logic we);
    int l;
    int idx;
    l   = n + 2;
    idx = edge_n - l + 1;
    chk($sformatf("n%0d e%0d we", n, edge_n), int'(we), (edge_n >= l) ? 1 : 0, 0);
    if (idx >= 1 && idx < 64 && cap_on[idx])
      chk($sformatf("n%0d e%0d out", n, edge_n), int'(od), int'(cap_exp[idx]), cap_tol[idx]);
  endtask

  task automatic cycle(input logic [15:0] d, input logic [15:0] e, input int tol, input bit on);
    data = d;
    if (edge_n + 1 < 64) begin
      cap_exp[edge_n+1] = e;
      cap_tol[edge_n+1] = tol;
      cap_on[edge_n+1]  = on;
    end
    @(posedge CLK);
    edge_n++;
    @(negedge CLK);
    chk_dut(4, od4, we4);
    chk_dut(3, od3, we3);
    chk_dut(6, od6, we6);
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 64; i++) begin
      cap_exp[i] = '0;
      cap_tol[i] = 0;
      cap_on[i]  = 1'b0;
    end
  endtask

  initial begin
    RST  = 1'b1;
    data = 16'h0000;
    clear_caps();
    repeat (2) @(negedge CLK);
    RST    = 1'b0;
    edge_n = 0;

    // zero held, then back-to-back stream, negative range, saturation boundary
    cycle(16'h0000, 16'h0400, 3, 1);
    cycle(16'h0000, 16'h0400, 3, 1);
    cycle(16'h0000, 16'h0400, 3, 1);
    cycle(16'h0200, 16'h0698, 4, 1);
    cycle(16'h0400, 16'h0AE0, 6, 1);
    cycle(16'h0600, 16'h11ED, 10, 1);
    cycle(16'h0800, 16'h1D8E, 16, 1);
    cycle(16'hFC00, 16'h0179, 1, 1);
    cycle(16'hE000, 16'h0000, 1, 1);
    cycle(16'h8000, 16'h0000, 0, 1);
    cycle(16'h1400, 16'hFFFF, 0, 1);
    cycle(16'h7FFF, 16'hFFFF, 0, 1);
    cycle(16'h10A2, 16'hFFD3, 132, 1);
    cycle(16'h10A3, 16'hFFFF, 0, 1);
    cycle(16'h0600, 16'h11ED, 10, 1);
    cycle(16'h0200, 16'h0698, 4, 1);
    cycle(16'h0800, 16'h1D8E, 16, 1);

    // one-cycle reset with samples in flight: outputs clear immediately
    RST = 1'b1;
    #1;
    chk("rst n4 out", int'(od4), 0, 0);
    chk("rst n4 we",  int'(we4), 0, 0);
    chk("rst n3 out", int'(od3), 0, 0);
    chk("rst n3 we",  int'(we3), 0, 0);
    chk("rst n6 out", int'(od6), 0, 0);
    chk("rst n6 we",  int'(we6), 0, 0);
    @(negedge CLK);
    RST    = 1'b0;
    edge_n = 0;
    clear_caps();

    cycle(16'h0800, 16'h1D8E, 16, 1);
    cycle(16'h0200, 16'h0698, 4, 1);
    cycle(16'hFC00, 16'h0179, 1, 1);
    cycle(16'h0400, 16'h0AE0, 6, 1);
    cycle(16'h0600, 16'h11ED, 10, 1);
    for (int i = 0; i < 8; i++) cycle(16'h0000, 16'h0000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
